// File: rtl/seven_seg_bank_pkg.sv
// Shared seven-segment types, the active-low hex glyph table and its lookup.
// Segment bit order is a..g from bit 6 down to bit 0.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam seg_t SEG_HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   function automatic seg_t hex_to_seg(input logic [3:0] i_nibble);
      return SEG_HEX[i_nibble];
   endfunction

endpackage

// File: rtl/seven_seg_bank_if.sv
// Display bank bus: the producer drives value/strobe/controls, the bank drives pins.
// load is a single-cycle capture strobe with no ready; the bank always accepts it.
interface seven_seg_bank_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     blink_mask;
   logic                  lz_suppress;
   logic [7*DIGITS-1:0]   segments;
   logic [DIGITS-1:0]     dots;
   logic                  blink_phase;

   modport master (
      output enable, load, value, dp_in, blink_mask, lz_suppress,
      input  segments, dots, blink_phase
   );

   modport slave (
      input  enable, load, value, dp_in, blink_mask, lz_suppress,
      output segments, dots, blink_phase
   );
endinterface

// File: rtl/seven_seg_blink_timer.sv
// Free-running half-period counter; blink_phase flips each time it wraps.
// Phase starts visible (1) out of reset.
module seven_seg_blink_timer #(
   parameter int CLK_HZ   = 50000000,
   parameter int BLINK_HZ = 2
) (
   input  logic clk,
   input  logic rst,
   output logic o_blink_phase
);
   localparam int HALF = (BLINK_HZ > 0) ? CLK_HZ / (2 * BLINK_HZ) : 0;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

   if (HALF < 1) begin : g_bad_half
      $error("seven_seg_blink_timer: CLK_HZ/(2*BLINK_HZ) must be at least 1");
   end

   logic [CW-1:0] r_count;
   logic          r_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_phase <= 1'b1;
      end else if (r_count == CW'(HALF - 1)) begin
         r_count <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_blink_phase = r_phase;

endmodule

// File: rtl/seven_seg_bank.sv
// Multi-digit hex display driver: holding registers, leading-zero suppression,
// per-digit blink and decimal points, registered pin outputs.
module seven_seg_bank
   import seven_seg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int CLK_HZ     = 50000000,
   parameter int BLINK_HZ   = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              rst,
   seven_seg_bank_if.slave   bus
);
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_bank: DIGITS must be 1..8");
   end

   // XOR mask that turns the active-low glyphs into the board polarity.
   localparam seg_t POL = (ACTIVE_LOW != 0) ? 7'b0000000 : 7'b1111111;

   logic [4*DIGITS-1:0] r_value;
   logic [DIGITS-1:0]   r_dp;
   logic [DIGITS-1:0]   r_blink;
   logic [7*DIGITS-1:0] r_segments;
   logic [DIGITS-1:0]   r_dots;

   logic                w_phase;
   logic [DIGITS-1:0]   w_run;
   logic [DIGITS-1:0]   w_lz;
   logic [DIGITS-1:0]   w_blank;
   logic [7*DIGITS-1:0] w_seg_next;
   logic [DIGITS-1:0]   w_dot_next;

   seven_seg_blink_timer #(
      .CLK_HZ   (CLK_HZ),
      .BLINK_HZ (BLINK_HZ)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .o_blink_phase (w_phase)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= '0;
         r_dp    <= '0;
         r_blink <= '0;
      end else if (bus.load) begin
         r_value <= bus.value;
         r_dp    <= bus.dp_in;
         r_blink <= bus.blink_mask;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_nibble;
      logic       w_zero;

      assign w_nibble = r_value[g*4 +: 4];
      assign w_zero   = (w_nibble == 4'd0) && !r_dp[g];

      // w_run[g]: this digit and every digit above it are blank-able zeros.
      if (g == DIGITS - 1) begin : g_top
         assign w_run[g] = w_zero;
      end else begin : g_lower
         assign w_run[g] = w_zero & w_run[g+1];
      end

      if (g == 0) begin : g_units
         assign w_lz[g] = 1'b0;
      end else begin : g_upper
         assign w_lz[g] = bus.lz_suppress & w_run[g];
      end

      assign w_blank[g] = ~bus.enable | (r_blink[g] & ~w_phase);

      assign w_seg_next[g*7 +: 7] =
         ((w_blank[g] | w_lz[g]) ? SEG_BLANK : hex_to_seg(w_nibble)) ^ POL;

      assign w_dot_next[g] = ~(r_dp[g] & ~w_blank[g]) ^ POL[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_segments <= {DIGITS{SEG_BLANK ^ POL}};
         r_dots     <= {DIGITS{~POL[0]}};
      end else begin
         r_segments <= w_seg_next;
         r_dots     <= w_dot_next;
      end
   end

   assign bus.segments    = r_segments;
   assign bus.dots        = r_dots;
   assign bus.blink_phase = w_phase;

endmodule

// File: tb/tb_seven_seg_bank.sv
// Bench for seven_seg_bank (4 digits, half-period of 4 clocks) against a
// cycle-level reference model built from the display rules.
module tb_seven_seg_bank;

   localparam int DIGITS   = 4;
   localparam int CLK_HZ   = 8;
   localparam int BLINK_HZ = 1;
   localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

   logic clk;
   logic rst;

   seven_seg_bank_if #(.DIGITS(DIGITS)) bus ();

   seven_seg_bank #(
      .DIGITS     (DIGITS),
      .CLK_HZ     (CLK_HZ),
      .BLINK_HZ   (BLINK_HZ),
      .ACTIVE_LOW (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [6:0] glyph [16];
   initial begin
      glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111;
      glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
      glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
      glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0000100;
      glyph[10] = 7'b0000010; glyph[11] = 7'b1100000;
      glyph[12] = 7'b0110001; glyph[13] = 7'b1000010;
      glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;
   end

   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  m_blink;
   int          m_tick;
   logic [27:0] m_seg;
   logic [3:0]  m_dots;

   // Phase is a function of edges since reset: visible for HALF, dark for HALF.
   function automatic logic phase_of(input int tick);
      return ((tick / HALF) % 2) == 0;
   endfunction

   task automatic model_edge();
      int   top;
      logic ph;
      logic dark;
      logic lzb;
      if (rst) begin
         m_val = '0; m_dp = '0; m_blink = '0; m_tick = 0;
         m_seg = '1; m_dots = '1;
         return;
      end
      ph  = phase_of(m_tick);
      top = -1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (top < 0 && (m_val[i*4 +: 4] != 4'd0 || m_dp[i])) top = i;
      end
      for (int d = 0; d < DIGITS; d++) begin
         dark = !bus.enable || (m_blink[d] && !ph);
         lzb  = bus.lz_suppress && (d > top) && (d != 0);
         m_seg[d*7 +: 7] = (dark || lzb) ? 7'h7F : glyph[m_val[d*4 +: 4]];
         m_dots[d]       = !(m_dp[d] && !dark);
      end
      if (bus.load) begin
         m_val = bus.value; m_dp = bus.dp_in; m_blink = bus.blink_mask;
      end
      m_tick++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("segments", 32'(bus.segments), 32'(m_seg));
      check("dots", 32'(bus.dots), 32'(m_dots));
      check("blink_phase", 32'(bus.blink_phase), 32'(phase_of(m_tick)));
   endtask

   task automatic drive(input logic en, input logic ld, input logic [15:0] v,
                        input logic [3:0] dp, input logic [3:0] bm, input logic lz);
      bus.enable = en; bus.load = ld; bus.value = v;
      bus.dp_in = dp; bus.blink_mask = bm; bus.lz_suppress = lz;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      step();
      check("rst_segments", 32'(bus.segments), 32'h0FFFFFFF);
      check("rst_dots", 32'(bus.dots), 32'hF);
      check("rst_phase", 32'(bus.blink_phase), 32'd1);
      rst = 1'b0;

      drive(1'b1, 1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
      step();
      bus.load = 1'b0;
      step();
      check("hex_12AF", 32'(bus.segments),
            32'({7'b1001111, 7'b0010010, 7'b0000010, 7'b0111000}));

      drive(1'b1, 1'b1, 16'h0070, 4'h0, 4'h0, 1'b1);
      step();
      bus.load = 1'b0;
      step();
      check("lz_0070", 32'(bus.segments),
            32'({7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}));
      check("lz_0070_dots", 32'(bus.dots), 32'hF);

      drive(1'b1, 1'b1, 16'h0070, 4'b0100, 4'h0, 1'b1);
      step();
      bus.load = 1'b0;
      step();
      check("lz_dp_seg", 32'(bus.segments),
            32'({7'b1111111, 7'b0000001, 7'b0001111, 7'b0000001}));
      check("lz_dp_dots", 32'(bus.dots), 32'b1011);

      drive(1'b1, 1'b1, 16'h4321, 4'h0, 4'b0001, 1'b0);
      step();
      bus.load = 1'b0;
      for (int i = 0; i < 4 * HALF; i++) step();

      bus.enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("enable_off_blank", 32'(bus.segments), 32'h0FFFFFFF);
      end
      bus.enable = 1'b1;
      for (int i = 0; i < 3; i++) step();

      drive(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF, 1'b0);
      rst = 1'b1;
      step();
      check("midrst_phase", 32'(bus.blink_phase), 32'd1);
      check("midrst_blank", 32'(bus.segments), 32'h0FFFFFFF);
      rst = 1'b0;
      bus.load = 1'b0;
      step();
      step();
      check("midrst_discarded", 32'(bus.segments),
            32'({7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}));

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(39) == 0);
         drive(($urandom_range(7) != 0), ($urandom_range(3) == 0),
               16'($urandom), 4'($urandom_range(3) == 0 ? $urandom : 0),
               4'($urandom_range(2) == 0 ? $urandom : 0), 1'($urandom));
         if ($urandom_range(1) == 0) bus.value[15:8] = 8'h00;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_bank.md
Name: seven_seg_bank

Overview:
- Parametrised multi-digit successor to the single-digit hex-to-seven-segment decoder.
- Drives DIGITS direct-drive HEX displays from one registered value word.
- Adds a load strobe with a holding register, per-digit decimal points, leading-zero suppression, and per-digit blinking from an internal timer.
- Sits between the clock/counter logic and the board's active-low HEX pins.

Parameters:
- DIGITS, 4, number of displays; 1..8
- CLK_HZ, 50000000, clk frequency in Hz
- BLINK_HZ, 2, blink rate in Hz; one full on+off period = 1/BLINK_HZ
- ACTIVE_LOW, 1, 1 = lit segment driven 0 (board default); 0 = outputs inverted

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  0 = all digits blank
- load  in  1  capture value/dp_in/blink_mask into holding registers
- value  in  4*DIGITS  nibble i = hex digit i (digit 0 = least significant)
- dp_in  in  DIGITS  decimal point request per digit
- blink_mask  in  DIGITS  1 = digit blinks
- lz_suppress  in  1  1 = blank leading zeros (live, not latched)
- segments  out  7*DIGITS  7-bit group i = digit i, bit6=a .. bit0=g
- dots  out  DIGITS  decimal point per digit, same polarity as segments
- blink_phase  out  1  current blink phase, 1 = visible

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - Holding registers = 0.
  - Blink counter = 0; blink_phase = 1.
  - segments and dots = all unlit (all 1s when ACTIVE_LOW=1).
- Load:
  - On a clk edge with load=1, the holding registers capture the inputs.
  - Without load, the holding registers keep their value.
  - value, dp_in and blink_mask are ignored unless load=1.
- Output register: segments and dots are registered from the holding registers plus live enable, lz_suppress and blink_phase.
- Latency:
  - load to outputs: 2 edges.
  - enable or lz_suppress change to outputs: 1 edge.
  - blink_phase toggle to outputs: 1 edge.
- Decode table, active-low, a..g:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0000010, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
  - Blank = 1111111. When ACTIVE_LOW=0, every output bit is inverted.
- Leading-zero suppression (lz_suppress=1):
  - Scan from digit DIGITS-1 downward.
  - A digit is blanked while it and all higher digits are 0 with dp clear.
  - The first nonzero digit, or any digit with dp set, ends suppression.
  - Digit 0 is never suppressed.
- Blink timer:
  - Counter runs 0..HALF-1, where HALF = CLK_HZ/(2*BLINK_HZ).
  - At terminal count it wraps to 0 and blink_phase toggles.
  - The counter runs regardless of enable and load.
  - Elaboration error if HALF < 1.
- Blink blanking: when blink_phase=0, digits with held blink_mask=1 are blanked, segments and dot.
- Blanking priority: enable=0 blanks everything > blink blank > lz blank > normal decode.
- Dot output: lit when held dp=1 and the digit is not blanked by enable or blink. A dp digit is never lz-blanked.
- Simultaneous events:
  - rst with load: rst wins.
  - load during blink-off: the new mask takes effect on the next output edge, with the current phase.
- Reset mid-operation: all state returns to reset values on the same edge; outputs are blank on the following cycle.

Decomposition:
- Package seven_seg_pkg:
  - seg_t (logic[6:0]).
  - Constants SEG_BLANK and the 16-entry SEG_HEX table, active-low.
  - Function hex_to_seg(nibble).
- Sub-module seven_seg_blink_timer: counter and blink_phase, parametrised by CLK_HZ and BLINK_HZ.
- Per-digit decode is generated in the top level.

Test Plan:
- Reset then release, DIGITS=4 -> segments = all 1s and dots = 4'b1111 the cycle after rst; blink_phase = 1.
- load value=16'h12AF, dp=0, enable=1 -> 2 edges later, groups 3..0 = 1001111, 0010010, 0000010, 0111000.
- load value=16'h0070, lz_suppress=1 -> digits 3 and 2 = 1111111, digit 1 = 0001111, digit 0 = 0000001.
  - Then load dp_in=4'b0100 -> digit 2 = 0000001 with dot lit (0).
- CLK_HZ=8, BLINK_HZ=1 (HALF=4):
  - blink_phase toggles every 4 cycles.
  - blink_mask=4'b0001 -> digit 0 blank during the 4 off-cycles; other digits steady.
- enable=0 for 3 cycles, then 1 -> all blank one edge after the fall; restored one edge after the rise; blink counter unaffected.
- Mid-blink rst pulse with load asserted the same cycle -> holding registers 0, counter 0, phase 1; the load is discarded.
